// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Bundles the program loader's byte-stream input and the CPU instruction
// fetch port.
//   in_data    [7:0]  stream byte (master -> loader)
//   in_valid          in_data valid (master -> loader)
//   in_ready          loader can accept a byte (loader -> master)
//   fetch_addr [7:0]  CPU fetch address, the pc (master -> loader)
//   fetch_data [7:0]  combinational instruction byte (loader -> master)
// Modports: master = stream source / CPU side, slave = loader side.
// -----------------------------------------------------------------------------
interface prog_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] fetch_addr;
   logic [7:0] fetch_data;

   modport master (
      output in_data, in_valid, fetch_addr,
      input  in_ready, fetch_data
   );

   modport slave (
      input  in_data, in_valid, fetch_addr,
      output in_ready, fetch_data
   );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Write side of the instruction memory. Receives a framed program image
// (SYNC, LEN, LEN data bytes, CSUM) over a valid/ready byte stream and writes
// it into a 256x8 RAM whose combinational read port feeds the CPU. The CPU is
// held in reset until a frame with a good checksum has loaded.
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state except the RAM
//   bus         prog_loader_if.slave: byte stream in, instruction fetch out
//   cpu_reset   1 = hold the CPU in reset
//   loading     a frame is in progress (LEN, DATA or CSUM)
//   load_done   one-cycle pulse: frame loaded with a good checksum
//   load_error  sticky: the last frame failed its checksum
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] LOAD_BASE = 8'h00
) (
   input  logic          clk,
   input  logic          reset,
   prog_loader_if.slave  bus,
   output logic          cpu_reset,
   output logic          loading,
   output logic          load_done,
   output logic          load_error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] addr_q;
   logic [7:0] sum_q;
   logic [8:0] remaining_q;      // 9 bits: a length byte of 0 means 256
   logic       cpu_reset_q;
   logic       load_error_q;
   logic       load_done_q;

   logic       ready;
   logic       busy;
   logic       accept;
   logic [7:0] csum_total;

   logic [7:0] mem [256];

   assign accept     = bus.in_valid & ready;
   assign csum_total = sum_q + bus.in_data;   // good frame when this wraps to 0

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      ready   = 1'b1;
      busy    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && bus.in_data == SYNC_BYTE) state_d = LEN;
         end
         LEN: begin
            busy = 1'b1;
            if (accept) state_d = DATA;
         end
         DATA: begin
            busy = 1'b1;
            if (accept && remaining_q == 9'd1) state_d = CSUM;
         end
         CSUM: begin
            busy = 1'b1;
            if (accept) state_d = DONE;
         end
         DONE: begin
            ready   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= 8'h00;
         sum_q        <= 8'h00;
         remaining_q  <= 9'd0;
         cpu_reset_q  <= 1'b1;
         load_error_q <= 1'b0;
         load_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_done_q <= 1'b0;
         if (accept) begin
            unique case (state_q)
               IDLE: begin
                  if (bus.in_data == SYNC_BYTE) begin
                     // A sync while running starts a reload: stop the CPU now.
                     cpu_reset_q  <= 1'b1;
                     load_error_q <= 1'b0;
                     addr_q       <= LOAD_BASE;
                     sum_q        <= 8'h00;
                  end
               end
               LEN: begin
                  remaining_q <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
               end
               DATA: begin
                  addr_q      <= addr_q + 8'd1;
                  sum_q       <= csum_total;
                  remaining_q <= remaining_q - 9'd1;
               end
               CSUM: begin
                  if (csum_total == 8'h00) begin
                     cpu_reset_q <= 1'b0;
                     load_done_q <= 1'b1;
                  end else begin
                     load_error_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the RAM has no reset; a reset keeps whatever program bytes were
   // already written, and a resettable 256-entry array would not map to RAM.
   always_ff @(posedge clk) begin
      if (accept && state_q == DATA) mem[addr_q] <= bus.in_data;
   end

   // Zero-latency fetch: a same-cycle write is only visible after the edge.
   assign bus.fetch_data = mem[bus.fetch_addr];
   assign bus.in_ready   = ready;

   assign cpu_reset  = cpu_reset_q;
   assign loading    = busy;
   assign load_done  = load_done_q;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader. Two instances share clk/reset: dut0 with
// LOAD_BASE=00 and dut1 with LOAD_BASE=FE. Bytes are driven on the falling
// edge and outputs are sampled 1 ns after the rising edge or mid-cycle.
// -----------------------------------------------------------------------------
module tb_prog_loader;

   logic clk;
   logic reset;
   logic cpu_reset0, loading0, load_done0, load_error0;
   logic cpu_reset1, loading1, load_done1, load_error1;

   int passes;
   int fails;
   int total;

   prog_loader_if bus0 ();
   prog_loader_if bus1 ();

   prog_loader #(.SYNC_BYTE(8'hA5), .LOAD_BASE(8'h00)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus0.slave),
      .cpu_reset  (cpu_reset0),
      .loading    (loading0),
      .load_done  (load_done0),
      .load_error (load_error0)
   );

   prog_loader #(.SYNC_BYTE(8'hA5), .LOAD_BASE(8'hFE)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus1.slave),
      .cpu_reset  (cpu_reset1),
      .loading    (loading1),
      .load_done  (load_done1),
      .load_error (load_error1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one byte to the selected instance and return 1 ns after the
   // edge on which it transferred.
   task automatic send(input int which, input logic [7:0] b);
      logic rdy;
      int   n;
      n = 0;
      @(negedge clk);
      if (which == 0) begin bus0.in_data = b; bus0.in_valid = 1'b1; end
      else            begin bus1.in_data = b; bus1.in_valid = 1'b1; end
      rdy = (which == 0) ? bus0.in_ready : bus1.in_ready;
      while (!rdy && n < 20) begin
         @(negedge clk);
         rdy = (which == 0) ? bus0.in_ready : bus1.in_ready;
         n++;
      end
      check("send_ready_timeout", {15'd0, rdy}, 16'd1);
      @(posedge clk);
      #1;
      if (which == 0) bus0.in_valid = 1'b0;
      else            bus1.in_valid = 1'b0;
   endtask

   task automatic fetch0(input string tag, input logic [7:0] a, input logic [7:0] exp);
      bus0.fetch_addr = a;
      #1;
      check(tag, {8'd0, bus0.fetch_data}, {8'd0, exp});
   endtask

   task automatic fetch1(input string tag, input logic [7:0] a, input logic [7:0] exp);
      bus1.fetch_addr = a;
      #1;
      check(tag, {8'd0, bus1.fetch_data}, {8'd0, exp});
   endtask

   initial begin
      passes = 0;
      fails  = 0;
      total  = 0;
      reset  = 1'b0;
      bus0.in_data = 8'h00; bus0.in_valid = 1'b0; bus0.fetch_addr = 8'h00;
      bus1.in_data = 8'h00; bus1.in_valid = 1'b0; bus1.fetch_addr = 8'h00;

      // 1. asynchronous reset before any clock edge
      #2 reset = 1'b1;
      #1;
      check("rst_cpu_reset",  {15'd0, cpu_reset0},    16'd1);
      check("rst_in_ready",   {15'd0, bus0.in_ready}, 16'd1);
      check("rst_loading",    {15'd0, loading0},      16'd0);
      check("rst_load_done",  {15'd0, load_done0},    16'd0);
      check("rst_load_error", {15'd0, load_error0},   16'd0);
      check("rst1_cpu_reset", {15'd0, cpu_reset1},    16'd1);
      @(negedge clk);
      reset = 1'b0;

      // 2. good frame A5,03,11,22,33,9A
      send(0, 8'hA5);
      check("t2_loading_len", {15'd0, loading0}, 16'd1);
      send(0, 8'h03);
      send(0, 8'h11);
      send(0, 8'h22);
      send(0, 8'h33);
      check("t2_cpu_reset_pre", {15'd0, cpu_reset0}, 16'd1);
      send(0, 8'h9A);
      check("t2_load_done",  {15'd0, load_done0},    16'd1);
      check("t2_ready_done", {15'd0, bus0.in_ready}, 16'd0);
      check("t2_cpu_reset",  {15'd0, cpu_reset0},    16'd0);
      check("t2_loading",    {15'd0, loading0},      16'd0);
      @(posedge clk); #1;
      check("t2_done_pulse", {15'd0, load_done0},    16'd0);
      check("t2_ready_idle", {15'd0, bus0.in_ready}, 16'd1);
      check("t2_cpu_run",    {15'd0, cpu_reset0},    16'd0);
      fetch0("t2_mem0", 8'h00, 8'h11);
      fetch0("t2_mem1", 8'h01, 8'h22);
      fetch0("t2_mem2", 8'h02, 8'h33);

      // 3. bad checksum, then a good frame clears the error
      send(0, 8'hA5);
      check("t3_reload_cpu_reset", {15'd0, cpu_reset0}, 16'd1);
      send(0, 8'h02);
      send(0, 8'h10);
      send(0, 8'h20);
      send(0, 8'h00);
      check("t3_no_done",    {15'd0, load_done0},  16'd0);
      check("t3_error",      {15'd0, load_error0}, 16'd1);
      check("t3_cpu_reset",  {15'd0, cpu_reset0},  16'd1);
      @(posedge clk); #1;
      check("t3_error_sticky", {15'd0, load_error0}, 16'd1);
      check("t3_no_done2",     {15'd0, load_done0},  16'd0);
      fetch0("t3_mem0", 8'h00, 8'h10);
      fetch0("t3_mem1", 8'h01, 8'h20);
      fetch0("t3_mem2", 8'h02, 8'h33);
      send(0, 8'hA5);
      check("t3_error_clear", {15'd0, load_error0}, 16'd0);
      send(0, 8'h01);
      send(0, 8'h77);
      send(0, 8'h89);
      check("t3_good_done", {15'd0, load_done0}, 16'd1);
      check("t3_good_run",  {15'd0, cpu_reset0}, 16'd0);

      // 4. leading junk, gaps on in_valid, sync byte as data
      send(0, 8'h00);
      repeat (2) @(posedge clk);
      send(0, 8'hFF);
      repeat (3) @(posedge clk);
      send(0, 8'h3C);
      check("t4_junk_idle", {15'd0, loading0}, 16'd0);
      check("t4_junk_run",  {15'd0, cpu_reset0}, 16'd0);
      send(0, 8'hA5);
      repeat (2) @(posedge clk);
      send(0, 8'h01);
      repeat (3) @(posedge clk); #1;
      check("t4_gap_hold", {15'd0, loading0}, 16'd1);
      send(0, 8'hA5);
      repeat (2) @(posedge clk); #1;
      check("t4_gap_csum", {15'd0, loading0}, 16'd1);
      send(0, 8'h5B);
      check("t4_done",  {15'd0, load_done0}, 16'd1);
      check("t4_error", {15'd0, load_error0}, 16'd0);
      fetch0("t4_mem0", 8'h00, 8'hA5);
      fetch0("t4_mem1", 8'h01, 8'h20);

      // 5. LOAD_BASE=FE wraps the address
      send(1, 8'hA5);
      send(1, 8'h03);
      send(1, 8'h01);
      send(1, 8'h02);
      send(1, 8'h03);
      send(1, 8'hFA);
      check("t5_done", {15'd0, load_done1}, 16'd1);
      check("t5_run",  {15'd0, cpu_reset1}, 16'd0);
      fetch1("t5_memFE", 8'hFE, 8'h01);
      fetch1("t5_memFF", 8'hFF, 8'h02);
      fetch1("t5_mem00", 8'h00, 8'h03);

      // 6. length 00 = 256 bytes, checksum 80
      send(0, 8'hA5);
      send(0, 8'h00);
      for (int i = 0; i < 256; i++) begin
         send(0, 8'(i));
         if (i == 255) check("t6_csum_state", {15'd0, loading0}, 16'd1);
      end
      send(0, 8'h80);
      check("t6_done", {15'd0, load_done0}, 16'd1);
      fetch0("t6_mem00", 8'h00, 8'h00);
      fetch0("t6_mem7F", 8'h7F, 8'h7F);
      fetch0("t6_memFF", 8'hFF, 8'hFF);

      // 6b. same frame, reset after 100 data bytes
      send(0, 8'hA5);
      send(0, 8'h00);
      for (int i = 0; i < 100; i++) send(0, ~8'(i));
      #2 reset = 1'b1;
      #1;
      check("t6r_loading",   {15'd0, loading0},      16'd0);
      check("t6r_cpu_reset", {15'd0, cpu_reset0},    16'd1);
      check("t6r_ready",     {15'd0, bus0.in_ready}, 16'd1);
      @(negedge clk);
      reset = 1'b0;
      fetch0("t6r_mem00", 8'h00, 8'hFF);
      fetch0("t6r_mem63", 8'h63, 8'h9C);
      fetch0("t6r_mem64", 8'h64, 8'h64);
      @(posedge clk); #1;
      check("t6r_idle", {15'd0, loading0}, 16'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader. It is the write side of the Prelude instruction memory, which the CPU only ever reads. It receives a framed program image over a valid/ready byte interface and writes it into a 256x8 instruction RAM. The RAM's combinational fetch port drives the CPU's instruction register in place of the fixed ROM, and the block holds the CPU in reset until a frame loads with a good checksum.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
LOAD_BASE, 8'h00, RAM address of the first data byte; the address wraps mod 256.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
in_data  input  8  incoming stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte; a byte transfers on a rising clk edge with in_valid & in_ready
fetch_addr  input  8  CPU fetch address (the pc)
fetch_data  output  8  combinational read: mem[fetch_addr]
cpu_reset  output  1  reset for the CPU core; 1 = hold the CPU in reset
loading  output  1  a frame is in progress (state is not IDLE or DONE)
load_done  output  1  one-cycle pulse: frame loaded, checksum good
load_error  output  1  sticky: last frame failed its checksum

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE, cpu_reset=1, load_done=0, load_error=0, in_ready=1, loading=0.
  - Internal address and checksum accumulator clear.
  - RAM contents are not cleared.
- States:
  - IDLE: accepted bytes other than SYNC_BYTE are discarded. An accepted SYNC_BYTE sets cpu_reset=1, clears load_error, loads addr=LOAD_BASE and sum=0, then goes to LEN.
  - LEN: the accepted byte sets remaining = byte, with 0 meaning 256 (9-bit counter). Goes to DATA.
  - DATA: each accepted byte writes mem[addr]<=in_data, then addr<=addr+1 (8-bit wrap), sum<=sum+in_data (mod 256), remaining<=remaining-1. After the last byte (remaining==1) goes to CSUM.
  - CSUM: the accepted byte c is checked for (sum+c) mod 256 == 0, then the block goes to DONE.
    - Good: on that edge cpu_reset<=0, and load_done=1 for exactly the DONE cycle.
    - Bad: load_error<=1, cpu_reset stays 1, load_done stays 0.
  - DONE: lasts exactly one cycle with in_ready=0, then returns to IDLE.
- in_ready=1 in every state except DONE.
- in_valid may drop in any state; the FSM holds with no side effects.
- Bytes are written as they arrive, before the checksum is verified. A failed frame therefore leaves partial contents in RAM while the CPU stays in reset.
- SYNC_BYTE arriving in LEN, DATA or CSUM is treated as ordinary data. There is no resync mid-frame.
- A sync byte in IDLE after a good load re-asserts cpu_reset on that edge (reload while running).
- Reset mid-frame returns the block to IDLE immediately with cpu_reset=1. Bytes already written stay in RAM.
- fetch_data has zero latency. A read of the address being written in the same cycle returns the old value; the new value is visible after the edge.
- Latency: load_done is asserted in the cycle after the checksum byte is accepted. cpu_reset falls on the same edge.

Test Plan:
1. Assert reset asynchronously (no clk edge) -> cpu_reset=1, in_ready=1, loading=0, load_done=0, load_error=0.
2. Stream A5,03,11,22,33,9A -> mem[0..2]=11,22,33; load_done high for one cycle after 9A; in_ready=0 that cycle; cpu_reset=0; fetch_addr=01 gives fetch_data=22.
3. Stream A5,02,10,20,00 (bad checksum) -> load_error=1, no load_done, cpu_reset=1, mem[0..1]=10,20. A following good frame clears load_error when its A5 is accepted.
4. Stream 00,FF,3C then A5,01,A5,5B, with in_valid gaps between bytes -> leading bytes ignored; A5 stored as data at mem[0]; good load.
5. LOAD_BASE=8'hFE, stream A5,03,01,02,03,FA -> mem[FE]=01, mem[FF]=02, mem[00]=03 (wrap); load_done.
6. Length 00 with 256 bytes i=0..255, checksum 80 -> all 256 written and load_done. Repeat with reset asserted after 100 data bytes -> IDLE, cpu_reset=1, mem[0..99] retained.
